// File: rtl/uart_rx.sv
// uart_rx - 8N1 asynchronous serial receiver for the rx232 pad.
//
// The pin is synchronized, then a falling edge starts a frame. Each bit is
// sampled three times around its centre, and the majority of those samples
// decides the bit. Each received byte is presented through a one-entry
// valid/ready holding register.
//
// Ports:
//   clk          in   system clock (48 MHz)
//   reset_n      in   asynchronous active-low reset
//   rx           in   raw serial input from the pad, idle high
//   rx_data      out  [7:0] received byte, valid while rx_valid=1
//   rx_valid     out  holding register full
//   rx_ready     in   consumer accepts the byte when rx_valid & rx_ready
//   rx_frame_err out  stop bit sampled 0 for the byte in rx_data
//   rx_overrun   out  one-cycle pulse: a completed byte was dropped
//   rx_break     out  one-cycle pulse: byte 0x00 with stop bit 0
//   rx_busy      out  receiver is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_break,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int H     = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;

    state_t           state,   state_n;
    logic [CNT_W-1:0] cnt,     cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift_q, shift_n;
    logic [1:0]       samp_q,  samp_n;
    logic             stop_q,  stop_n;
    logic             dlv_q,   dlv_n;

    logic cnt_wrap;
    logic at_dec;
    logic vote;

    // ------------------------------------------------------------------
    // Synchronizer. Flops reset to 1 so that reset release on an idle
    // line never looks like a start edge.
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            samp_q  <= '0;
            stop_q  <= 1'b1;
            dlv_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift_q <= shift_n;
            samp_q  <= samp_n;
            stop_q  <= stop_n;
            dlv_q   <= dlv_n;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next state and datapath
    // ------------------------------------------------------------------
    assign cnt_wrap = (cnt == CNT_LAST);
    assign at_dec   = (cnt == CNT_DEC);
    // The third sample is the live synchronized value at the decision point.
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // NOTE: every variable gets a default before the case statement, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt_wrap ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift_q;
        samp_n    = samp_q;
        stop_n    = stop_q;
        dlv_n     = 1'b0;

        if (cnt == CNT_S0) samp_n[0] = rx_s;
        if (cnt == CNT_S1) samp_n[1] = rx_s;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (rx_s_d && !rx_s) state_n = S_START;
            end
            S_START: begin
                if (at_dec && vote) begin
                    // High at the start-bit centre: a glitch, not a frame.
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt_wrap) begin
                    state_n   = S_DATA;
                    bit_idx_n = '0;
                end
            end
            S_DATA: begin
                if (at_dec) shift_n = {vote, shift_q[7:1]};
                if (cnt_wrap) begin
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                // Deliver at the stop-bit centre so a back-to-back start bit
                // is never missed.
                if (at_dec) begin
                    dlv_n   = 1'b1;
                    stop_n  = vote;
                    cnt_n   = '0;
                    state_n = vote ? S_IDLE : S_BRK_WAIT;
                end
            end
            S_BRK_WAIT: begin
                // Wait for the line to return high before hunting for a new
                // start edge.
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign rx_busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Holding register and status pulses. The delivery cycle is the cycle
    // in which dlv_q is high. A byte arriving while the register is full is
    // dropped unless the consumer accepts in that same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_break     <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            rx_break   <= 1'b0;
            if (dlv_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data      <= shift_q;
                    rx_frame_err <= !stop_q;
                    rx_valid     <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
                rx_break <= !stop_q && (shift_q == 8'h00);
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - scoreboard bench for uart_rx at 417 clocks per bit.
// Stimulus pushes the expected byte/flag into a queue. A monitor pops the
// queue and compares on every accepted byte (rx_valid & rx_ready).
module tb_uart_rx;

    localparam int CPB   = 417;
    localparam int H     = CPB / 2;
    localparam int SYNC  = 2;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_break;
    logic       rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t expq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;
    int brk_cnt  = 0;
    int cyc      = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_break    (rx_break),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // One 8N1 frame. glitch_bit selects a data bit that gets a one-cycle
    // inversion at its centre (-1 for none).
    task automatic send_byte(input logic [7:0] d, input logic stop_b, input int glitch_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < CPB; c++) begin
                rx = (i == glitch_bit && c == H) ? ~d[i] : d[i];
                tick();
            end
        end
        rx = stop_b;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic ferr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        expq.push_back(e);
    endtask

    task automatic measure(output int t_busy, output int t_valid);
        int  t0;
        bit  seen;
        t0      = cyc;
        seen    = 1'b0;
        t_busy  = -1;
        t_valid = -1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (rx_busy) seen = 1'b1;
            else if (seen && t_busy < 0) t_busy = cyc - t0;
            if (rx_valid && t_valid < 0) t_valid = cyc - t0;
            if (t_busy >= 0 && t_valid >= 0) break;
        end
    endtask

    // Raise rx_ready for exactly the cycle after the stop decision.
    task automatic ready_at_delivery(output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (rx_busy) begin
                seen = 1'b1;
            end else if (seen) begin
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: compare every accepted byte, count status pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    check("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, e.ferr});
                end
            end
            if (rx_overrun) ovr_cnt++;
            if (rx_break)   brk_cnt++;
        end
    end

    initial begin
        #(95_000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        int  t_busy;
        int  t_valid;
        int  ovr0;
        int  brk0;
        bit  ok;

        // Reset state
        repeat (3) tick();
        check("reset_rx_data", {24'd0, rx_data}, 32'h0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("reset_flags", {28'd0, rx_frame_err, rx_overrun, rx_break, rx_busy}, 32'h0);
        reset_n = 1'b1;
        idle(20);

        // Basic byte and latency
        push(8'hA5, 1'b0);
        fork
            send_byte(8'hA5, 1'b1, -1);
            measure(t_busy, t_valid);
        join
        check_range("busy_fall_latency", t_busy,
                    (SYNC + 1) + 9 * CPB + H + 1, (SYNC + 1) + 9 * CPB + H + 3);
        check_range("valid_latency", t_valid,
                    (SYNC + 1) + 9 * CPB + H + 1, (SYNC + 1) + 9 * CPB + H + 3);
        idle(CPB);

        // False start from a short low pulse
        rx = 1'b0;
        repeat (150) tick();
        idle(2 * CPB);
        check("false_start_idle", {31'd0, rx_busy}, 32'h0);
        push(8'h5A, 1'b0);
        send_byte(8'h5A, 1'b1, -1);
        idle(CPB);

        // Framing error without break
        brk0 = brk_cnt;
        push(8'h3C, 1'b1);
        send_byte(8'h3C, 1'b0, -1);
        idle(CPB);
        check("ferr_no_break", brk_cnt - brk0, 0);
        push(8'h81, 1'b0);
        send_byte(8'h81, 1'b1, -1);
        idle(CPB);

        // Break: line low for 20 bit times
        brk0 = brk_cnt;
        push(8'h00, 1'b1);
        rx = 1'b0;
        repeat (20 * CPB) tick();
        check("break_wait_busy", {31'd0, rx_busy}, 32'h1);
        idle(2 * CPB);
        check("break_pulses", brk_cnt - brk0, 1);
        push(8'h7E, 1'b0);
        send_byte(8'h7E, 1'b1, -1);
        idle(CPB);

        // Overrun: second byte dropped while the first is held
        ovr0 = ovr_cnt;
        rx_ready = 1'b0;
        push(8'h11, 1'b0);
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b1, -1);
        idle(CPB);
        check("overrun_pulses", ovr_cnt - ovr0, 1);
        check("overrun_keeps_old", {24'd0, rx_data}, 32'h11);
        check("overrun_valid", {31'd0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        tick();

        // Accept coinciding with delivery: no overrun, new byte loaded
        ovr0 = ovr_cnt;
        rx_ready = 1'b0;
        push(8'h11, 1'b0);
        send_byte(8'h11, 1'b1, -1);
        push(8'h22, 1'b0);
        fork
            send_byte(8'h22, 1'b1, -1);
            ready_at_delivery(ok);
        join
        idle(CPB);
        check("coincide_watch", {31'd0, ok}, 32'h1);
        check("coincide_no_overrun", ovr_cnt - ovr0, 0);
        check("coincide_new_data", {24'd0, rx_data}, 32'h22);
        rx_ready = 1'b1;
        tick();

        // Single-cycle glitch at the centre of data bit 3
        push(8'h00, 1'b0);
        send_byte(8'h00, 1'b1, 3);
        idle(CPB);

        // Reset mid-frame with a byte held in the register
        rx_ready = 1'b0;
        send_byte(8'hE7, 1'b1, -1);
        idle(CPB);
        check("held_before_reset", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hE7});
        rx = 1'b0;
        repeat (CPB + CPB / 2) tick();
        rx = 1'b1;
        repeat (CPB) tick();
        check("busy_mid_frame", {31'd0, rx_busy}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {20'd0, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_break, rx_busy}, 32'h0);
        rx_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        idle(2 * CPB);
        push(8'hC3, 1'b0);
        send_byte(8'hC3, 1'b1, -1);
        idle(CPB);

        check("scoreboard_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver for the rx232 pad; it is the receive counterpart of the board's RS232 transmit path on tx232.
- Synchronizes the pin and detects and validates the start bit.
- Samples each bit at its centre using a 3-sample majority vote.
- Presents each received byte through a one-entry valid/ready holding register.
- Sits in blaster_chip on the 48 MHz clk domain and feeds future command/telemetry logic.

Parameters:
- CLKS_PER_BIT, 417, clk cycles per bit (48 MHz / 115200 baud, rounded); legal range 8..65535.
- SYNC_STAGES, 2, number of synchronizer flops on rx; legal values 2 or 3.

Ports:
- clk  input  1  system clock (48 MHz).
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  raw serial input from the pad; idle high.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- rx_frame_err  output  1  stop bit sampled 0 for the byte in rx_data; qualified by rx_valid.
- rx_overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- rx_break  output  1  one-cycle pulse: break detected (data=0x00 and stop=0).
- rx_busy  output  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - Synchronizer flops set to 1; state=IDLE; counters cleared.
  - rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_break=0, rx_busy=0.
  - Reset asserted mid-frame abandons the frame with no partial output.
- rx_s is the synchronized rx (SYNC_STAGES flops). rx_s_d is rx_s delayed one cycle.
- Counters:
  - Bit-phase counter cnt is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1, then wraps.
  - H = CLKS_PER_BIT/2 (integer division).
  - Within each bit, rx_s is sampled at cnt = H-1, H and H+1.
  - The bit value is the majority of the three samples, decided at cnt = H+1.
- States:
  - IDLE: on rx_s_d=1 & rx_s=0, go to START with cnt=0.
  - START: at the decision point, vote=1 is a false start and returns to IDLE with no output. vote=0 stays in START until cnt = CLKS_PER_BIT-1, then goes to DATA with cnt=0 and bit index=0.
  - DATA: the decided bit is shifted in LSB first. At cnt = CLKS_PER_BIT-1, bit index increments. After bit 7 completes, go to STOP with cnt=0.
  - STOP: the byte is delivered at the decision point, without waiting for the end of the stop bit. Vote=1 goes to IDLE. Vote=0 goes to BRK_WAIT.
  - BRK_WAIT: stay until rx_s=1, then go to IDLE. No start detection happens while in BRK_WAIT.
- Delivery (the cycle after the STOP decision):
  - If rx_valid=0, or rx_ready=1 in that cycle: load rx_data and rx_frame_err; rx_valid=1.
  - Otherwise: keep the old byte and its flag, drop the new byte, and pulse rx_overrun.
  - rx_break pulses in the delivery cycle when stop=0 and byte=0x00, regardless of overrun.
- Handshake:
  - When rx_valid & rx_ready, rx_valid clears next cycle unless a delivery coincides.
  - When a delivery coincides with the accept, rx_valid stays 1 with the new data and there is no overrun.
  - rx_ready while rx_valid=0 has no effect.
  - rx_data and rx_frame_err hold their values after the accept until the next load.
- Latency:
  - From rx falling edge to START entry: SYNC_STAGES+1 cycles.
  - From the falling edge to rx_valid: (SYNC_STAGES+1) + 9*CLKS_PER_BIT + H + 2 cycles, ±1.
- A single-cycle glitch at any bit centre is rejected by the majority vote.
- Glitches shorter than H cycles at the start bit give a false start and no output.

Test Plan:
- Byte 0xA5 at 417 clk/bit, stop=1, rx_ready=1 → one rx_valid cycle; rx_data=0xA5; rx_frame_err=0; rx_busy falls to 0 at the stop decision.
- 150-cycle low pulse on an idle line → no rx_valid; state returns to IDLE; a subsequent 0x5A is received correctly.
- 0x3C with stop bit 0, then line high → rx_data=0x3C, rx_frame_err=1, no rx_break. Then 0x81 is received with rx_frame_err=0.
- Line held low for 20 bit times → exactly one byte 0x00 with rx_frame_err=1 and one rx_break pulse; no further bytes until rx goes high; the next 0x7E is received.
- rx_ready=0, bytes 0x11 then 0x22 back-to-back → rx_data stays 0x11 and rx_overrun pulses once. Repeat with rx_ready=1 in the second delivery cycle → rx_data=0x22, no overrun.
- Single-cycle inverted glitch at the centre of data bit 3 of 0x00 → rx_data=0x00. reset_n pulsed low mid-byte → all outputs 0 immediately; the next full frame 0xC3 is received correctly.
